fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage upstream of DP_mem32x64k: owns the PC, drives the memory address port,
//  captures the 1-cycle-latency read data and hands {pc, instr} to decode over a valid/ready handshake.
//  2-entry buffer sustains 1 instr/cycle under backpressure; supports redirect (branch/jump) and halt.
// PARAMETERS
//  WORD      32       instruction/data width, matches memory D/Q
//  ADDR      16       word-address width, matches memory A
//  RESET_PC  16'h0000 PC loaded at reset
//  DEPTH     2        output buffer entries (fixed at 2; other values unsupported)
// PORTS
//  clk            in   1     clock, all state on posedge
//  reset          in   1     synchronous, active-low reset
//  mem_a          out  ADDR  memory address (combinational from pc)
//  mem_w          out  1     memory write enable, constant 0
//  mem_d          out  WORD  memory write data, constant 0
//  mem_q          in   WORD  memory read data, valid 1 cycle after mem_a
//  redirect_valid in   1     load new PC, flush pipeline
//  redirect_pc    in   ADDR  target word address
//  halt           in   1     stop issuing new reads (level)
//  out_valid      out  1     buffer head holds an instruction
//  out_ready      in   1     decode accepts head this cycle
//  out_pc         out  ADDR  PC of head instruction
//  out_instr      out  WORD  head instruction
//  busy           out  1     read in flight or buffer non-empty
// BEHAVIOUR
//  - Reset (reset==0 at posedge): pc=RESET_PC, inflight=0, count=0, state=BOOT; out_valid=0,
//    out_pc=0, out_instr=0, busy=0. mem_w=0 and mem_d=0 at all times.
//  - FSM: BOOT -> RUN after one cycle (no issue in BOOT). RUN -> HALT when halt=1 and no redirect.
//    HALT -> RUN on redirect_valid (takes priority over halt). halt=0 while in HALT does not resume.
//  - Issue (RUN only): issue = (count + inflight - deq) < 2, deq = out_valid & out_ready.
//    On issue: inflight<=1, tag_pc<=pc, pc<=pc+1 (mod 2^ADDR; 16'hFFFF wraps to 16'h0000).
//  - Capture: inflight==1 at cycle n -> mem_q enqueued with tag_pc at end of n; out_valid from n+1.
//  - Simultaneous enqueue+dequeue: allowed, count unchanged. Enqueue never overflows (credit rule).
//  - Steady state with out_ready=1: one instruction per cycle, consecutive PCs, no bubbles.
//  - out_ready=0: head and its payload held stable; buffer fills to 2, then issue stops.
//  - Redirect at cycle t: buffer flushed (count=0), in-flight read squashed (its mem_q dropped),
//    pc<=redirect_pc; out_valid=0 in t+1; mem_a=redirect_pc in t+1; first instr out_valid in t+3.
//    Any dequeue in cycle t still counts as accepted by decode.
//  - Redirect during BOOT: accepted; state -> RUN.
//  - Reset mid-operation: all state cleared regardless of inflight/count; redirect/halt ignored.
//  - busy = inflight | (count!=0).
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_fetched (32b, +1 per dequeue) and perf_stall (32b,
//    +1 per RUN cycle where out_valid=0); both reset to 0, wrap at 2^32, not cleared by redirect.
//  FETCH_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. mem[0..9]=32'hA000_0000+i, out_ready=1 after reset release -> instrs A0000000..A0000009 with
//     out_pc 0..9 on consecutive cycles, first out_valid 3 cycles after reset deasserts.
//  2. out_ready=0 for 5 cycles mid-stream -> out_pc/out_instr stable, count==2, no issue;
//     on release no instruction lost or duplicated.
//  3. redirect_valid with redirect_pc=16'h0100 while buffer full and read in flight -> next accepted
//     out_pc=16'h0100, none of the flushed PCs appear; out_valid 3 cycles after redirect.
//  4. Start at redirect_pc=16'hFFFE -> out_pc sequence FFFE, FFFF, 0000, 0001.
//  5. halt=1 at pc=5 -> already issued instrs drain, then out_valid=0 and busy=0 indefinitely;
//     redirect to 16'h0020 -> fetch resumes from 0x0020.
//  6. reset pulled low with count=2 -> next cycle out_valid=0, busy=0; restart from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage that sits in front of a 1-cycle-latency word memory
// (DP_mem32x64k). It owns the PC and drives the memory address straight from
// it. The read data is captured one cycle later together with the PC that
// produced it. The resulting {pc, instr} pairs are queued in a 2-entry buffer
// and offered to decode. Redirects (branch/jump) flush everything in flight.
// A level halt stops new reads until the next redirect.
//
// Optional feature: define FETCH_PERF_EN to add the perf_fetched / perf_stall
// performance counters. The default build leaves the macro undefined.
//
// Ports
//   clk            in   1     clock, all state updates on posedge
//   reset          in   1     synchronous, active-low reset
//   mem_a          out  ADDR  memory word address (combinational from pc)
//   mem_w          out  1     memory write enable, tied to 0
//   mem_d          out  WORD  memory write data, tied to 0
//   mem_q          in   WORD  memory read data, valid 1 cycle after mem_a
//   redirect_valid in   1     load redirect_pc, flush buffer and in-flight read
//   redirect_pc    in   ADDR  redirect target word address
//   halt           in   1     stop issuing new reads (level)
//   out_valid      out  1     buffer head holds an instruction
//   out_ready      in   1     decode accepts the head this cycle
//   out_pc         out  ADDR  PC of head instruction
//   out_instr      out  WORD  head instruction
//   busy           out  1     read in flight or buffer non-empty
//   fsm_state      out  2     current control state (BOOT=0, RUN=1, HALT=2)
//   perf_fetched   out  32    (FETCH_PERF_EN) dequeues, wraps at 2^32
//   perf_stall     out  32    (FETCH_PERF_EN) RUN cycles with out_valid=0
//
// Handshake: a transfer to decode happens on a rising edge where out_valid
// and out_ready are both 1. While out_valid=1 and out_ready=0, out_pc and
// out_instr are held stable. out_valid never depends on out_ready.
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int              WORD     = 32,
    parameter int              ADDR     = 16,
    parameter logic [ADDR-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [ADDR-1:0] mem_a,
    output logic            mem_w,
    output logic [WORD-1:0] mem_d,
    input  logic [WORD-1:0] mem_q,
    input  logic            redirect_valid,
    input  logic [ADDR-1:0] redirect_pc,
    input  logic            halt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ADDR-1:0] out_pc,
    output logic [WORD-1:0] out_instr,
    output logic            busy,
    output logic [1:0]      fsm_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Credit limit for the buffer; the design is built for exactly 2 entries.
    localparam logic [2:0] CREDITS = 3'(DEPTH);

    state_t          state_q, state_d;
    logic [ADDR-1:0] pc_q;
    logic [ADDR-1:0] tag_pc_q;
    logic            inflight_q;
    logic [1:0]      count_q, count_d;

    // Slot 0 is always the head; slot 1 is only meaningful when count_q==2.
    logic [ADDR-1:0] s0_pc_q, s0_pc_d, s1_pc_q, s1_pc_d;
    logic [WORD-1:0] s0_in_q, s0_in_d, s1_in_q, s1_in_d;

    logic            deq;
    logic            enq;
    logic            issue;
    logic [2:0]      occupancy;

    // ------------------------------------------------------------------------
    // Control FSM. A redirect always wins over halt, and it is the only way
    // out of HALT. BOOT lasts exactly one cycle and never issues.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (!redirect_valid && halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // ------------------------------------------------------------------------
    // Issue and capture.
    // occupancy counts entries that will be in the buffer once this cycle's
    // dequeue is gone and any read in flight has landed. A new read is issued
    // only if a slot is still free for it. That keeps enqueues from
    // overflowing without any back-pressure path to the memory.
    // ------------------------------------------------------------------------
    assign deq       = out_valid & out_ready;
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, deq};
    assign issue     = (state_q == ST_RUN) && !redirect_valid && !halt &&
                       (occupancy < CREDITS);

    // A redirect squashes the read returning this cycle.
    assign enq = inflight_q && !redirect_valid;

    // ------------------------------------------------------------------------
    // Buffer next-state. The dequeue shift is applied first. The enqueue then
    // writes the first free slot left after that shift.
    // ------------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        s0_pc_d = s0_pc_q;
        s0_in_d = s0_in_q;
        s1_pc_d = s1_pc_q;
        s1_in_d = s1_in_q;
        if (redirect_valid) begin
            count_d = 2'd0;
        end else begin
            if (deq) begin
                s0_pc_d = s1_pc_q;
                s0_in_d = s1_in_q;
            end
            if (enq) begin
                if ((count_q == 2'd0) || ((count_q == 2'd1) && deq)) begin
                    s0_pc_d = tag_pc_q;
                    s0_in_d = mem_q;
                end else begin
                    s1_pc_d = tag_pc_q;
                    s1_in_d = mem_q;
                end
            end
            count_d = count_q + {1'b0, enq} - {1'b0, deq};
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            tag_pc_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            s0_pc_q    <= '0;
            s0_in_q    <= '0;
            s1_pc_q    <= '0;
            s1_in_q    <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            count_q    <= count_d;
            s0_pc_q    <= s0_pc_d;
            s0_in_q    <= s0_in_d;
            s1_pc_q    <= s1_pc_d;
            s1_in_q    <= s1_in_d;
            if (redirect_valid) begin
                pc_q <= redirect_pc;
            end else if (issue) begin
                pc_q <= pc_q + 1'b1;
            end
            if (issue) begin
                tag_pc_q <= pc_q;
            end
        end
    end

    // Structural invariants of the credit scheme.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (count_q <= 2'd2);
            assert (!(enq && !deq && (count_q == 2'd2)));
        end
    end

    // ------------------------------------------------------------------------
    // Optional performance counters. A redirect does not clear them.
    // ------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            if (deq) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if ((state_q == ST_RUN) && !out_valid) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mem_a     = pc_q;
    assign mem_w     = 1'b0;
    assign mem_d     = '0;
    assign out_valid = (count_q != 2'd0);
    assign out_pc    = s0_pc_q;
    assign out_instr = s0_in_q;
    assign busy      = inflight_q | (count_q != 2'd0);
    assign fsm_state = state_q;

endmodule
